// File: rtl/time_counter_pkg.sv
// Shared timekeeping constants and width helper, reused by the BCD split
// and display mux stages.
package time_counter_pkg;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int HR_MOD  = 24;

    // Bits needed to hold 0..value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/time_counter_if.sv
// Control inputs and time outputs of the timekeeping core.
interface time_counter_if #(
    parameter int DWL = 8
) ();

    logic           en;
    logic           set_mode;
    logic           inc_min;
    logic           inc_hr;
    logic [5:0]     Seconds;
    logic [DWL-3:0] Minutes;
    logic [DWL-4:0] Hours;
    logic           tick_1hz;

    // tick_1hz is a one-cycle strobe marking a freshly advanced Seconds value;
    // there is no ready, the consumer samples it in that cycle or misses it.
    // inc_min / inc_hr are one-cycle pulses; every high cycle counts as a press.
    modport master (
        output en, set_mode, inc_min, inc_hr,
        input  Seconds, Minutes, Hours, tick_1hz
    );

    modport slave (
        input  en, set_mode, inc_min, inc_hr,
        output Seconds, Minutes, Hours, tick_1hz
    );

endinterface

// File: rtl/time_counter_mod_counter.sv
// Modulo-MOD up-counter with a same-cycle carry out on the wrap increment.
module mod_counter #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // Anything at or past the last legal value wraps, so a corrupted
    // register recovers on its next increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (inc) begin
            if (value >= LAST) begin
                value <= '0;
            end else begin
                value <= value + W'(1);
            end
        end
    end

    assign carry = inc && (value == LAST);

endmodule

// File: rtl/time_counter.sv
// 24-hour timekeeping core: 1 Hz prescaler, H:M:S carry chain and a set mode
// for manual minute/hour adjustment.
module time_counter
    import time_counter_pkg::*;
#(
    parameter int DWL      = 8,
    parameter int CLK_FREQ = 100000000
) (
    input  logic           clk,
    input  logic           reset,
    time_counter_if.slave  bus
);

    localparam int            PW = clog2(CLK_FREQ);
    localparam logic [PW-1:0] TC = PW'(CLK_FREQ - 1);

    logic [PW-1:0]  presc;
    logic           run;
    logic           wrap;
    logic           tick_q;
    logic           sec_clr;
    logic           min_inc;
    logic           hr_inc;
    logic           sec_carry;
    logic           min_carry;
    logic           day_wrap_unused;
    logic [5:0]     sec_val;
    logic [DWL-3:0] min_val;
    logic [DWL-4:0] hr_val;

    assign run  = ~bus.set_mode & bus.en;
    assign wrap = run && (presc == TC);

    // Set mode parks the prescaler at 0 so the first tick after leaving
    // it is a full period away; en=0 simply freezes it mid-count.
    always_ff @(posedge clk) begin
        if (reset || bus.set_mode) begin
            presc <= '0;
        end else if (run) begin
            presc <= wrap ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= wrap;
        end
    end

    assign sec_clr = reset | bus.set_mode;
    assign min_inc = bus.set_mode ? bus.inc_min : sec_carry;
    assign hr_inc  = bus.set_mode ? bus.inc_hr  : min_carry;

    mod_counter #(.MOD(SEC_MOD), .W(6)) u_sec (
        .clk   (clk),
        .reset (sec_clr),
        .inc   (wrap),
        .value (sec_val),
        .carry (sec_carry)
    );

    mod_counter #(.MOD(MIN_MOD), .W(DWL - 2)) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (min_inc),
        .value (min_val),
        .carry (min_carry)
    );

    mod_counter #(.MOD(HR_MOD), .W(DWL - 3)) u_hr (
        .clk   (clk),
        .reset (reset),
        .inc   (hr_inc),
        .value (hr_val),
        .carry (day_wrap_unused)
    );

    assign bus.Seconds  = sec_val;
    assign bus.Minutes  = min_val;
    assign bus.Hours    = hr_val;
    assign bus.tick_1hz = tick_q;

endmodule

// File: tb/tb_time_counter.sv
module tb_time_counter;

  localparam int DWL      = 8;
  localparam int CLK_FREQ = 4;
  localparam int EW       = 18;
  localparam int WATCHDOG = 5000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  time_counter_if #(.DWL(DWL)) bus ();

  time_counter #(.DWL(DWL), .CLK_FREQ(CLK_FREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Scoreboard entry: {Hours[4:0], Minutes[5:0], Seconds[5:0], tick}
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            done  = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_t(input string nm, input int h, input int m,
                          input int s, input logic t);
    exp_q.push_back({5'(h), 6'(m), 6'(s), t});
    name_q.push_back(nm);
  endtask

  task automatic step_expect(input string nm, input int h, input int m,
                             input int s, input logic t);
    step();
    expect_t(nm, h, m, s, t);
  endtask

  task automatic pulse(input logic mi, input logic hi);
    bus.inc_min = mi;
    bus.inc_hr  = hi;
    step();
    bus.inc_min = 1'b0;
    bus.inc_hr  = 1'b0;
  endtask

  // n full tick periods starting right after a prescaler restart at 0
  task automatic run_ticks(input string nm, input int h, input int m,
                           input int s0, input int n);
    for (int k = 1; k <= n; k++) begin
      for (int c = 0; c < CLK_FREQ - 1; c++) begin
        step_expect(nm, h, m, s0 + k - 1, 1'b0);
      end
      step_expect(nm, h, m, s0 + k, 1'b1);
    end
  endtask

  // Direct check of the reset state, independent of the scoreboard
  task automatic check_reset_state(input string nm);
    n_cmp++;
    if (bus.Hours !== '0 || bus.Minutes !== '0 || bus.Seconds !== '0 ||
        bus.tick_1hz !== 1'b0) begin
      n_err++;
      $display("FAIL %s: reset state %0d:%0d:%0d tick=%b", nm,
               bus.Hours, bus.Minutes, bus.Seconds, bus.tick_1hz);
    end
  endtask

  // Bounded wait for a tick; reports an expired wait as a failure
  task automatic wait_tick(input string nm, input int max_cycles);
    int cnt;
    cnt = 0;
    while (bus.tick_1hz !== 1'b1 && cnt < max_cycles) begin
      step();
      cnt++;
    end
    n_cmp++;
    if (bus.tick_1hz !== 1'b1) begin
      n_err++;
      $display("FAIL %s: no tick within %0d cycles", nm, max_cycles);
    end
  endtask

  // Monitor: one queued expectation is checked per falling edge
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    string         nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {bus.Hours, bus.Minutes, bus.Seconds, bus.tick_1hz};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s: got %0d:%0d:%0d tick=%b, expected %0d:%0d:%0d tick=%b",
                   nm, a[17:13], a[12:7], a[6:1], a[0],
                   e[17:13], e[12:7], e[6:1], e[0]);
        end
      end
    end
  end

  // Watchdog: the whole run must finish within a bounded number of cycles
  initial begin
    repeat (WATCHDOG) @(posedge clk);
    if (!done) begin
      n_err++;
      $display("FAIL watchdog: stimulus did not finish within %0d cycles", WATCHDOG);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    reset        = 1'b1;
    bus.en       = 1'b1;
    bus.set_mode = 1'b0;
    bus.inc_min  = 1'b0;
    bus.inc_hr   = 1'b0;
    step();
    step();
    check_reset_state("reset_direct");
    step_expect("reset", 0, 0, 0, 1'b0);

    // Tick cadence after reset release
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step_expect("pre_tick1", 0, 0, 0, 1'b0);
    step_expect("tick1", 0, 0, 1, 1'b1);
    for (int i = 0; i < 3; i++) step_expect("between_ticks", 0, 0, 1, 1'b0);
    step_expect("tick2", 0, 0, 2, 1'b1);
    step_expect("after_tick2", 0, 0, 2, 1'b0);

    // Set mode, simultaneous increments
    bus.set_mode = 1'b1;
    step_expect("set_enter", 0, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) pulse(1'b1, 1'b1);
    expect_t("set_1010", 10, 10, 0, 1'b0);
    for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0);
    expect_t("set_1020", 10, 20, 0, 1'b0);
    pulse(1'b1, 1'b1);
    expect_t("both_inc", 11, 21, 0, 1'b0);

    // Run mode ignores increments; first tick a full period after exit
    bus.set_mode = 1'b0;
    bus.inc_min  = 1'b1;
    bus.inc_hr   = 1'b1;
    step_expect("run_ignore_inc", 11, 21, 0, 1'b0);
    step_expect("run_ignore_inc", 11, 21, 0, 1'b0);
    bus.inc_min  = 1'b0;
    bus.inc_hr   = 1'b0;
    step_expect("exit_latency", 11, 21, 0, 1'b0);
    step_expect("first_tick", 11, 21, 1, 1'b1);

    // Enable hold at prescaler count 2
    step_expect("pre_hold", 11, 21, 1, 1'b0);
    step_expect("pre_hold", 11, 21, 1, 1'b0);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) step_expect("en_hold", 11, 21, 1, 1'b0);
    bus.en = 1'b1;
    step_expect("en_resume", 11, 21, 1, 1'b0);
    step_expect("en_tick", 11, 21, 2, 1'b1);

    // Minute and hour wrap in set mode
    bus.set_mode = 1'b1;
    step_expect("set_enter2", 11, 21, 0, 1'b0);
    for (int i = 0; i < 12; i++) pulse(1'b1, 1'b1);
    for (int i = 0; i < 26; i++) pulse(1'b1, 1'b0);
    expect_t("set_2359", 23, 59, 0, 1'b0);
    pulse(1'b1, 1'b0);
    expect_t("min_wrap_no_carry", 23, 0, 0, 1'b0);
    pulse(1'b0, 1'b1);
    expect_t("hr_wrap", 0, 0, 0, 1'b0);

    // Full-day rollover
    for (int i = 0; i < 23; i++) pulse(1'b1, 1'b1);
    for (int i = 0; i < 36; i++) pulse(1'b1, 1'b0);
    expect_t("preset_2359", 23, 59, 0, 1'b0);
    bus.set_mode = 1'b0;
    run_ticks("run_to_235959", 23, 59, 0, 59);
    for (int i = 0; i < 3; i++) step_expect("hold_235959", 23, 59, 59, 1'b0);
    step_expect("rollover", 0, 0, 0, 1'b1);

    // Reset priority
    bus.set_mode = 1'b1;
    step_expect("set_enter3", 0, 0, 0, 1'b0);
    for (int i = 0; i < 12; i++) pulse(1'b1, 1'b1);
    for (int i = 0; i < 22; i++) pulse(1'b1, 1'b0);
    expect_t("set_1234", 12, 34, 0, 1'b0);
    bus.set_mode = 1'b0;
    run_ticks("run_to_123456", 12, 34, 0, 56);
    step_expect("mid_prescale", 12, 34, 56, 1'b0);
    step_expect("mid_prescale", 12, 34, 56, 1'b0);
    reset = 1'b1;
    step_expect("reset_mid", 0, 0, 0, 1'b0);
    bus.set_mode = 1'b1;
    bus.inc_min  = 1'b1;
    bus.inc_hr   = 1'b1;
    step_expect("reset_vs_inc", 0, 0, 0, 1'b0);
    check_reset_state("reset_vs_inc_direct");
    bus.set_mode = 1'b0;
    bus.inc_min  = 1'b0;
    bus.inc_hr   = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step_expect("pre_reset_tick", 0, 0, 0, 1'b0);
    reset = 1'b1;
    step_expect("reset_vs_tick", 0, 0, 0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step_expect("post_reset", 0, 0, 0, 1'b0);
    step_expect("post_reset_tick", 0, 0, 1, 1'b1);

    repeat (2) @(negedge clk);
    #1;
    wait_tick("wait_next_tick", CLK_FREQ + 1);

    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
